zorro_slot_arbiter: RTL and testbench

Arbitrates the five Zorro expansion slots for bus mastership. Decodes each slot's EBR line, tracking Zorro III register/deregister pulses and Zorro II level requests. Selects one slot round-robin and drives its EBG. Exchanges a level handshake with the core's bus-master sequencer, which owns BR/BG/BGACK towards the CPU and the buffer direction.

---
 rtl/zorro_slot_arbiter_if.sv | 29 ++
 rtl/zorro_slot_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_zorro_slot_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zorro_slot_arbiter_if.sv
`default_nettype none
// ==== zorro_slot_arbiter_if: slot/sequencer signals of the Zorro slot arbiter (rev 1.0) ====
interface zorro_slot_arbiter_if;
  logic       c7m_falling;
  logic [4:0] ebr_n_in;
  logic       ebgack_n_in;
  logic       bus_granted;
  logic       bus_req;
  logic       bus_is_z3;
  logic [2:0] grant_slot;
  logic       tenure_done;
  logic       timeout_err;
  logic [4:0] ebg_n_out;
  logic [4:0] ebg_n_oe;
  logic [4:0] z3_registered;

  modport master (
    input  c7m_falling, ebr_n_in, ebgack_n_in, bus_granted,
    output bus_req, bus_is_z3, grant_slot, tenure_done, timeout_err,
           ebg_n_out, ebg_n_oe, z3_registered
  );

  modport slave (
    output c7m_falling, ebr_n_in, ebgack_n_in, bus_granted,
    input  bus_req, bus_is_z3, grant_slot, tenure_done, timeout_err,
           ebg_n_out, ebg_n_oe, z3_registered
  );
endinterface
`default_nettype wire

// File: rtl/zorro_slot_arbiter.sv
`default_nettype none
// ==== zorro_slot_arbiter: round-robin EBR/EBG arbiter for five Zorro slots (rev 1.0) ====
module zorro_slot_arbiter #(
  parameter int          NSLOTS         = 5,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  wire logic            clk100,
  input  wire logic            reset_n,
  zorro_slot_arbiter_if.master slot_if
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_TENURE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [2:0]  c_last_rst = 3'(NSLOTS - 1);
  localparam logic [15:0] c_tmo_last = TIMEOUT_CYCLES - 16'd1;

  logic [4:0]      r_ebr_s1, r_ebr_s2;
  logic            r_ack_s1, r_ack_s2;
  logic [4:0]      r_p0, r_p1, r_p2;
  logic [4:0][1:0] r_inh;
  logic [4:0]      r_z3;

  state_t      r_state, w_state_nx;
  logic        r_bus_req, w_req_nx;
  logic        r_is_z3, w_is_z3_nx;
  logic [2:0]  r_grant, w_grant_nx;
  logic        r_done, w_done_nx;
  logic        r_terr, w_terr_nx;
  logic [4:0]  r_ebg, w_ebg_nx;
  logic [4:0]  r_oe;
  logic [15:0] r_cnt, w_cnt_nx;
  logic        r_ack_seen, w_seen_nx;
  logic [2:0]  r_last, w_last_nx;

  logic [4:0] w_inh_act, w_pulse, w_z3_next, w_z2_req, w_cand;
  logic [2:0] w_pick;
  logic       w_pick_ok, w_withdraw;

  function automatic logic [2:0] f_wrap(input logic [2:0] base, input logic [2:0] step);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, step};
    return (s >= 4'(NSLOTS)) ? 3'(s - 4'(NSLOTS)) : s[2:0];
  endfunction

  for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
    assign w_inh_act[i] = |r_inh[i];
  end

  // A 1,0,1 history is a Z3 (de)registration pulse; a pending toggle already counts for arbitration
  assign w_pulse   = r_p2 & ~r_p1 & r_p0 & ~w_inh_act;
  assign w_z3_next = r_z3 ^ w_pulse;
  assign w_z2_req  = ~r_p1 & ~r_p0 & ~r_z3 & ~w_inh_act;
  assign w_cand    = (|w_z3_next) ? w_z3_next : w_z2_req;

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      r_ebr_s1 <= '1;
      r_ebr_s2 <= '1;
      r_ack_s1 <= 1'b1;
      r_ack_s2 <= 1'b1;
      r_p0     <= '1;
      r_p1     <= '1;
      r_p2     <= '1;
      r_inh    <= '0;
      r_z3     <= '0;
    end else begin
      r_ebr_s1 <= slot_if.ebr_n_in;
      r_ebr_s2 <= r_ebr_s1;
      r_ack_s1 <= slot_if.ebgack_n_in;
      r_ack_s2 <= r_ack_s1;
      r_z3     <= w_z3_next;
      for (int i = 0; i < NSLOTS; i++) begin
        if (w_pulse[i]) begin
          r_p2[i]  <= 1'b0;
          r_p1[i]  <= 1'b0;
          r_p0[i]  <= 1'b0;
          r_inh[i] <= 2'd3;
        end else if (slot_if.c7m_falling) begin
          r_p2[i] <= r_p1[i];
          r_p1[i] <= r_p0[i];
          r_p0[i] <= r_ebr_s2[i];
          if (w_inh_act[i]) r_inh[i] <= r_inh[i] - 2'd1;
        end
      end
    end
  end

  // Descending scan so the slot nearest after r_last is the one left standing
  always_comb begin
    w_pick    = '0;
    w_pick_ok = 1'b0;
    for (int k = NSLOTS; k >= 1; k--) begin
      if (w_cand[f_wrap(r_last, 3'(k))]) begin
        w_pick    = f_wrap(r_last, 3'(k));
        w_pick_ok = 1'b1;
      end
    end
  end

  assign w_withdraw = r_is_z3 ? ~r_z3[r_grant] : r_p0[r_grant];

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_bus_req;
    w_is_z3_nx = r_is_z3;
    w_grant_nx = r_grant;
    w_done_nx  = 1'b0;
    w_terr_nx  = 1'b0;
    w_ebg_nx   = '1;
    w_cnt_nx   = r_cnt;
    w_seen_nx  = r_ack_seen;
    w_last_nx  = r_last;
    case (r_state)
      S_IDLE: begin
        w_req_nx = 1'b0;
        if (w_pick_ok) begin
          w_state_nx = S_REQ;
          w_req_nx   = 1'b1;
          w_grant_nx = w_pick;
          w_is_z3_nx = |w_z3_next;
        end
      end
      S_REQ: begin
        if (w_withdraw) begin
          w_state_nx = S_RELEASE;
          w_req_nx   = 1'b0;
          w_done_nx  = 1'b1;
        end else if (slot_if.bus_granted) begin
          w_state_nx        = S_TENURE;
          w_ebg_nx[r_grant] = 1'b0;
          w_last_nx         = r_grant;
          w_cnt_nx          = '0;
          w_seen_nx         = 1'b0;
        end
      end
      S_TENURE: begin
        if (r_is_z3) begin
          if (!r_z3[r_grant]) begin
            w_state_nx = S_RELEASE;
            w_req_nx   = 1'b0;
            w_done_nx  = 1'b1;
          end else begin
            w_ebg_nx[r_grant] = 1'b0;
          end
        end else if (r_ebg[r_grant] && r_ack_s2) begin
          w_state_nx = S_RELEASE;
          w_req_nx   = 1'b0;
          w_done_nx  = 1'b1;
        end else if (!r_ack_seen && r_ack_s2 && (r_cnt == c_tmo_last)) begin
          w_state_nx = S_RELEASE;
          w_req_nx   = 1'b0;
          w_done_nx  = 1'b1;
          w_terr_nx  = 1'b1;
        end else begin
          w_ebg_nx[r_grant] = r_ebr_s2[r_grant];
          w_cnt_nx          = r_ack_s2 ? r_cnt + 16'd1 : 16'd0;
          w_seen_nx         = r_ack_seen | ~r_ack_s2;
        end
      end
      S_RELEASE: begin
        w_req_nx = 1'b0;
        if (!slot_if.bus_granted) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bus_req  <= 1'b0;
      r_is_z3    <= 1'b0;
      r_grant    <= '0;
      r_done     <= 1'b0;
      r_terr     <= 1'b0;
      r_ebg      <= '1;
      r_oe       <= '0;
      r_cnt      <= '0;
      r_ack_seen <= 1'b0;
      r_last     <= c_last_rst;
    end else begin
      r_state    <= w_state_nx;
      r_bus_req  <= w_req_nx;
      r_is_z3    <= w_is_z3_nx;
      r_grant    <= w_grant_nx;
      r_done     <= w_done_nx;
      r_terr     <= w_terr_nx;
      r_ebg      <= w_ebg_nx;
      r_oe       <= '1;
      r_cnt      <= w_cnt_nx;
      r_ack_seen <= w_seen_nx;
      r_last     <= w_last_nx;
    end
  end

  assign slot_if.bus_req       = r_bus_req;
  assign slot_if.bus_is_z3     = r_is_z3;
  assign slot_if.grant_slot    = r_grant;
  assign slot_if.tenure_done   = r_done;
  assign slot_if.timeout_err   = r_terr;
  assign slot_if.ebg_n_out     = r_ebg;
  assign slot_if.ebg_n_oe      = r_oe;
  assign slot_if.z3_registered = r_z3;
endmodule
`default_nettype wire

// File: tb/tb_zorro_slot_arbiter.sv
`default_nettype none
// ==== tb_zorro_slot_arbiter: directed checks for zorro_slot_arbiter (rev 1.0) ====
module tb_zorro_slot_arbiter;
  localparam logic [15:0] c_tmo = 16'd200;

  logic clk100  = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   done_cnt   = 0;
  int   terr_cnt   = 0;
  int   ebglow_cnt = 0;

  zorro_slot_arbiter_if ifc ();

  zorro_slot_arbiter #(
    .NSLOTS        (5),
    .TIMEOUT_CYCLES(c_tmo)
  ) dut (
    .clk100 (clk100),
    .reset_n(reset_n),
    .slot_if(ifc)
  );

  always #5 clk100 = ~clk100;

  // One C7M falling strobe every fourth clk100 edge
  initial begin
    ifc.c7m_falling = 1'b0;
    forever begin
      repeat (3) @(posedge clk100);
      #1 ifc.c7m_falling = 1'b1;
      @(posedge clk100);
      #1 ifc.c7m_falling = 1'b0;
    end
  end

  always @(negedge clk100) begin
    if (ifc.tenure_done) done_cnt++;
    if (ifc.timeout_err) terr_cnt++;
    if (ifc.ebg_n_out != 5'h1f) ebglow_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic wait_strobe();
    do @(posedge clk100); while (!ifc.c7m_falling);
    #1;
  endtask

  task automatic z3_pulse(input logic [4:0] m);
    wait_strobe();
    ifc.ebr_n_in = ifc.ebr_n_in & ~m;
    wait_strobe();
    ifc.ebr_n_in = ifc.ebr_n_in | m;
    repeat (5) wait_strobe();
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (ifc.bus_req !== 1'b1 && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(ifc.bus_req), 1);
  endtask

  task automatic do_reset();
    reset_n         = 1'b0;
    ifc.ebr_n_in    = 5'h1f;
    ifc.ebgack_n_in = 1'b1;
    ifc.bus_granted = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic rr_step(input int slot, input logic [4:0] end_mask);
    logic [4:0] exp_ebg;
    exp_ebg       = 5'h1f;
    exp_ebg[slot] = 1'b0;
    wait_req("rr_req");
    chk("rr_grant", 32'(ifc.grant_slot), slot);
    chk("rr_z3", 32'(ifc.bus_is_z3), 1);
    ifc.bus_granted = 1'b1;
    tick(1);
    chk("rr_ebg", 32'(ifc.ebg_n_out), 32'(exp_ebg));
    z3_pulse(end_mask);
    chk("rr_ebg_off", 32'(ifc.ebg_n_out), 'h1f);
    ifc.bus_granted = 1'b0;
    tick(2);
  endtask

  initial begin
    int d, e, t, n;
    ifc.ebr_n_in    = 5'h1f;
    ifc.ebgack_n_in = 1'b1;
    ifc.bus_granted = 1'b0;
    reset_n         = 1'b0;
    tick(3);
    chk("rst_ebg", 32'(ifc.ebg_n_out), 'h1f);
    chk("rst_oe", 32'(ifc.ebg_n_oe), 0);
    chk("rst_z3", 32'(ifc.z3_registered), 0);
    chk("rst_req", 32'(ifc.bus_req), 0);
    chk("rst_grant", 32'(ifc.grant_slot), 0);
    chk("rst_is_z3", 32'(ifc.bus_is_z3), 0);
    chk("rst_done", 32'(ifc.tenure_done), 0);
    chk("rst_terr", 32'(ifc.timeout_err), 0);
    reset_n = 1'b1;
    tick(1);
    chk("oe_on", 32'(ifc.ebg_n_oe), 'h1f);

    // Z3 basic on slot 2
    z3_pulse(5'b00100);
    chk("z3b_reg", 32'(ifc.z3_registered), 'b00100);
    wait_req("z3b_req");
    chk("z3b_is_z3", 32'(ifc.bus_is_z3), 1);
    chk("z3b_grant", 32'(ifc.grant_slot), 2);
    chk("z3b_no_ebg", 32'(ifc.ebg_n_out), 'h1f);
    ifc.bus_granted = 1'b1;
    tick(1);
    chk("z3b_ebg", 32'(ifc.ebg_n_out), 'b11011);
    d = done_cnt;
    z3_pulse(5'b00100);
    chk("z3b_ebg_off", 32'(ifc.ebg_n_out), 'h1f);
    chk("z3b_done", 32'(done_cnt - d), 1);
    chk("z3b_dereg", 32'(ifc.z3_registered), 0);
    ifc.bus_granted = 1'b0;
    tick(3);
    chk("z3b_idle", 32'(ifc.bus_req), 0);

    // Round robin across slots 0, 1, 3
    do_reset();
    z3_pulse(5'b01011);
    chk("rr_reg", 32'(ifc.z3_registered), 'b01011);
    rr_step(0, 5'b00001);
    rr_step(1, 5'b00011);
    rr_step(3, 5'b01000);
    rr_step(0, 5'b00001);

    // Z2 handshake on slot 4
    do_reset();
    ifc.ebr_n_in = 5'b01111;
    wait_req("z2_req");
    chk("z2_is_z3", 32'(ifc.bus_is_z3), 0);
    chk("z2_grant", 32'(ifc.grant_slot), 4);
    ifc.bus_granted = 1'b1;
    tick(1);
    chk("z2_ebg", 32'(ifc.ebg_n_out), 'b01111);
    ifc.ebgack_n_in = 1'b0;
    tick(6);
    chk("z2_hold", 32'(ifc.ebg_n_out), 'b01111);
    d = done_cnt;
    ifc.ebr_n_in = 5'h1f;
    tick(3);
    chk("z2_ebg_neg", 32'(ifc.ebg_n_out), 'h1f);
    chk("z2_not_done", 32'(done_cnt - d), 0);
    t = terr_cnt;
    ifc.ebgack_n_in = 1'b1;
    tick(8);
    chk("z2_done", 32'(done_cnt - d), 1);
    chk("z2_no_terr", 32'(terr_cnt - t), 0);
    chk("z2_req_off", 32'(ifc.bus_req), 0);
    ifc.bus_granted = 1'b0;
    tick(2);

    // Z2 timeout on slot 1
    do_reset();
    ifc.ebr_n_in = 5'b11101;
    wait_req("tmo_req");
    chk("tmo_grant", 32'(ifc.grant_slot), 1);
    chk("tmo_is_z3", 32'(ifc.bus_is_z3), 0);
    ifc.bus_granted = 1'b1;
    tick(1);
    chk("tmo_ebg", 32'(ifc.ebg_n_out), 'b11101);
    n = 0;
    while (ifc.timeout_err !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(c_tmo));
    chk("tmo_done_with_err", 32'(ifc.tenure_done), 1);
    chk("tmo_ebg_off", 32'(ifc.ebg_n_out), 'h1f);
    tick(1);
    chk("tmo_err_width", 32'(ifc.timeout_err), 0);
    chk("tmo_done_width", 32'(ifc.tenure_done), 0);
    ifc.ebr_n_in = 5'h1f;
    repeat (3) wait_strobe();
    ifc.bus_granted = 1'b0;
    tick(2);

    // Z3 registration beats a Z2 request in the same strobe; then withdrawal in REQ
    do_reset();
    wait_strobe();
    ifc.ebr_n_in = 5'b10110;
    wait_strobe();
    ifc.ebr_n_in = 5'b11110;
    wait_strobe();
    wait_req("pri_req");
    chk("pri_grant", 32'(ifc.grant_slot), 3);
    chk("pri_is_z3", 32'(ifc.bus_is_z3), 1);
    chk("pri_reg", 32'(ifc.z3_registered), 'b01000);
    ifc.ebr_n_in = 5'h1f;
    repeat (4) wait_strobe();
    d = done_cnt;
    e = ebglow_cnt;
    z3_pulse(5'b01000);
    chk("wd_req_off", 32'(ifc.bus_req), 0);
    chk("wd_dereg", 32'(ifc.z3_registered), 0);
    chk("wd_done", 32'(done_cnt - d), 1);
    chk("wd_no_ebg", 32'(ebglow_cnt - e), 0);

    // Reset in the middle of a Z3 tenure
    do_reset();
    z3_pulse(5'b00100);
    wait_req("mid_req");
    ifc.bus_granted = 1'b1;
    tick(1);
    chk("mid_ebg", 32'(ifc.ebg_n_out), 'b11011);
    reset_n = 1'b0;
    tick(1);
    chk("mid_rst_ebg", 32'(ifc.ebg_n_out), 'h1f);
    chk("mid_rst_oe", 32'(ifc.ebg_n_oe), 0);
    chk("mid_rst_z3", 32'(ifc.z3_registered), 0);
    chk("mid_rst_req", 32'(ifc.bus_req), 0);
    reset_n         = 1'b1;
    ifc.bus_granted = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
